// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Packs opcode / immediate / register-address fields into 32-bit instruction
//   words and holds them in a program buffer. In LOAD the program is collected
//   and nothing is emitted. A start pulse releases it (RUN), and the words then
//   stream out in FIFO order. When the buffer drains, the encoder returns to
//   LOAD on its own.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous active-high reset
//   opcode_in    : [3:0]  opcode field
//   number_in    : [7:0]  immediate field
//   addr1/2/3_in : [4:0]  register address fields
//   in_valid     : field set offered this cycle
//   in_ready     : encoder can accept a field set (== !full)
//   start        : one-cycle pulse releasing the loaded program
//   instruction  : [31:0] head word while out_valid, else 32'h0
//   out_valid    : instruction holds a valid word
//   out_ready    : consumer takes the word this cycle
//   count        : [log2(DEPTH):0] number of stored words
//   full / empty : buffer status flags
//   running      : high while in RUN
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               opcode_in,
  input  logic [7:0]               number_in,
  input  logic [4:0]               addr1_in,
  input  logic [4:0]               addr2_in,
  input  logic [4:0]               addr3_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     start,
  output logic [31:0]              instruction,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     running
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_full;
  logic            r_empty;

  logic            w_push;
  logic            w_pop;
  logic            w_out_valid;
  logic [CW-1:0]   w_count_nxt;
  logic [31:0]     w_word;

  // Field packing; bits [27:23] are reserved and always zero.
  assign w_word = {opcode_in, 5'b00000, number_in, addr3_in, addr2_in, addr1_in};

  // Handshake qualifiers. A full buffer refuses pushes even when a pop
  // frees a slot at the same edge, so in_ready never depends on out_ready.
  assign w_out_valid = (r_state == ST_RUN) && !r_empty;
  assign w_push      = in_valid && !r_full;
  assign w_pop       = w_out_valid && out_ready;

  // Occupancy after this edge; drives the flags and the FSM decisions.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   w_count_nxt = r_count - {{(CW-1){1'b0}}, 1'b1};
      default: w_count_nxt = r_count;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state. LOAD leaves only when start sees a non-empty buffer
  // (a push at the same edge counts); RUN returns once the buffer drains.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: begin
        if (start && (w_count_nxt != {CW{1'b0}})) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (w_count_nxt == {CW{1'b0}}) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == {CW{1'b0}});
    end
  end

  // Program storage; contents are left as-is by reset since the
  // pointers and count already mark every entry as invalid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // Output word: head entry while valid, forced to zero otherwise.
  always_comb begin
    instruction = 32'h0000_0000;
    if (w_out_valid) begin
      instruction = r_mem[r_rd_ptr];
    end else begin
      instruction = 32'h0000_0000;
    end
  end

  assign in_ready  = !r_full;
  assign out_valid = w_out_valid;
  assign count     = r_count;
  assign full      = r_full;
  assign empty     = r_empty;
  assign running   = (r_state == ST_RUN);

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning program-buffer entries (power of two, 2..256).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port opcode_in, input, 4, instruction opcode field.
REQ-005 SHALL have port number_in, input, 8, immediate number field.
REQ-006 SHALL have ports addr1_in, addr2_in and addr3_in, input, 5 each, register address fields.
REQ-007 SHALL have port in_valid, input, 1, field set offered this cycle.
REQ-008 SHALL have port in_ready, output, 1, encoder can accept a field set.
REQ-009 SHALL have port start, input, 1, one-cycle pulse that releases the loaded program.
REQ-010 SHALL have port instruction, output, 32, encoded word to the control unit.
REQ-011 SHALL have port out_valid, output, 1, instruction holds a valid word.
REQ-012 SHALL have port out_ready, input, 1, consumer takes the word this cycle.
REQ-013 SHALL have port count, output, log2(DEPTH)+1, number of stored words.
REQ-014 SHALL have ports full and empty, output, 1 each, buffer status flags.
REQ-015 SHALL have port running, output, 1, high while in state RUN.

Function
REQ-016 SHALL pack each word as: [31:28]=opcode_in, [27:23]=5'b0, [22:15]=number_in, [14:10]=addr3_in, [9:5]=addr2_in, [4:0]=addr1_in.
REQ-017 SHALL push a packed word when in_valid && in_ready at a clock edge; in_ready SHALL equal !full, combinationally.
REQ-018 SHALL pop the head word when out_valid && out_ready at a clock edge.
REQ-019 SHALL store words in FIFO order with read/write pointers that wrap modulo DEPTH.
REQ-020 SHALL keep count exact, with count = DEPTH meaning full=1 and count = 0 meaning empty=1.
REQ-021 SHALL implement states LOAD and RUN, with running=1 only in RUN.
REQ-022 In LOAD, out_valid SHALL be 0, and pushes SHALL be accepted whenever in_ready=1.
REQ-023 LOAD SHALL go to RUN on start=1 with the buffer non-empty, counted after any push at that same edge.
REQ-024 start in LOAD with the buffer empty and no simultaneous push SHALL be ignored.
REQ-025 In RUN, out_valid SHALL equal !empty; pushes SHALL still be accepted, and start SHALL be ignored.
REQ-026 RUN SHALL go to LOAD at the edge where a pop leaves count = 0 and no push occurs at that edge.
REQ-027 instruction SHALL present the head word whenever out_valid=1, and SHALL be 32'h0 whenever out_valid=0.
REQ-028 Latency: a word pushed into an empty buffer during RUN SHALL appear with out_valid=1 in the next cycle; there SHALL be no combinational in-to-out path.
REQ-029 A simultaneous push and pop SHALL leave count unchanged and SHALL be legal at any non-empty, non-full occupancy.
REQ-030 When full, a push SHALL NOT occur (in_ready=0) even if a pop happens at that edge.
REQ-031 When empty, a pop SHALL NOT occur.
REQ-032 A held out_valid with out_ready=0 SHALL keep instruction stable until it is popped.

Reset
REQ-033 With reset=1 at a clock edge: state=LOAD, pointers=0, count=0, empty=1, full=0, in_ready=1, out_valid=0, running=0, instruction=32'h0.
REQ-034 Reset SHALL take priority over push, pop and start at the same edge.
REQ-035 Reset mid-RUN SHALL discard all stored words.
REQ-036 Storage array contents need not be cleared by reset.

Verification
REQ-037 Pack check: push opcode=4'hA, number=8'h5C, addr3=5'd3, addr2=5'd2, addr1=5'd1, then start with out_ready=1 -> instruction=32'hA02E0C41 next cycle, then running drops after the pop.
REQ-038 Hold-off: push 3 words with start low for 10 cycles -> out_valid stays 0 and count=3; start -> words emerge in order, one per cycle with out_ready=1.
REQ-039 Full: push DEPTH words -> full=1 and in_ready=0; a further in_valid is not stored; one pop -> in_ready=1 next cycle with count=DEPTH-1.
REQ-040 Wrap and concurrent traffic: 3*DEPTH random words with random in_valid/out_ready in RUN -> output sequence matches the scoreboard exactly and count never exceeds DEPTH.
REQ-041 Start corner cases: start with empty buffer -> stays LOAD; start coincident with the first push -> RUN, and the word is output next cycle.
REQ-042 Reset mid-RUN with count=5 -> next cycle count=0, out_valid=0, running=0, instruction=32'h0.
